// File: rtl/plic_gateway.sv
// Per-source PLIC interrupt gateway: synchronises raw IRQ lines and turns level or
// edge requests into single pending requests, gated by the claim/complete handshake.
module plic_gateway #(
  parameter int unsigned SRC_N       = 1,
  parameter int unsigned TGT_N       = 1,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_CNT_W  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [SRC_N-1:0]      int_src,
  output logic [SRC_N:0]        int_pending,
  input  logic [TGT_N-1:0]      claim_valid,
  input  logic [TGT_N-1:0][4:0] claim_id,
  input  logic [TGT_N-1:0]      complete_valid,
  input  logic [TGT_N-1:0][4:0] complete_id,
  input  logic [SRC_N:0]        cfg_int_edge
);

  typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_BUSY} state_e;

  logic [SRC_N-1:0] s_src;
  logic [SRC_N-1:0] s_prev_q;
  logic             unused_cfg;

  assign unused_cfg = cfg_int_edge[0];

  if (SYNC_STAGES == 0) begin : g_nosync
    assign s_src = int_src;
  end else begin : g_sync
    logic [SRC_N-1:0] sync_q [SYNC_STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
        sync_q[0] <= int_src;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
    end

    assign s_src = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s_prev_q <= '0;
    else        s_prev_q <= s_src;
  end

  assign int_pending[0] = 1'b0;

  for (genvar k = 1; k <= SRC_N; k++) begin : g_src
    state_e                state_q, state_d;
    logic [EDGE_CNT_W-1:0] cnt_q, cnt_d;
    logic                  claim_hit, complete_hit;
    logic                  edge_mode, rise, cnt_full;

    // Several targets naming the same source in one cycle collapse into one hit.
    always_comb begin
      claim_hit    = 1'b0;
      complete_hit = 1'b0;
      for (int unsigned t = 0; t < TGT_N; t++) begin
        if (claim_valid[t] && (claim_id[t] == 5'(k)))       claim_hit    = 1'b1;
        if (complete_valid[t] && (complete_id[t] == 5'(k))) complete_hit = 1'b1;
      end
    end

    assign edge_mode = cfg_int_edge[k];
    assign rise      = s_src[k-1] & ~s_prev_q[k-1];
    assign cnt_full  = &cnt_q;

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
        ST_IDLE: begin
          if (edge_mode ? rise : s_src[k-1]) state_d = ST_PEND;
        end
        ST_PEND: begin
          if (claim_hit) state_d = ST_BUSY;
          if (edge_mode && rise && !cnt_full) cnt_d = cnt_q + EDGE_CNT_W'(1);
        end
        ST_BUSY: begin
          if (complete_hit) begin
            // A rise coinciding with complete re-pends directly instead of being queued.
            if (edge_mode && rise) begin
              state_d = ST_PEND;
            end else if (edge_mode && (cnt_q != '0)) begin
              state_d = ST_PEND;
              cnt_d   = cnt_q - EDGE_CNT_W'(1);
            end else begin
              state_d = ST_IDLE;
            end
          end else if (edge_mode && rise && !cnt_full) begin
            cnt_d = cnt_q + EDGE_CNT_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
      if (!edge_mode) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    assign int_pending[k] = (state_q == ST_PEND);
  end

endmodule
